// File: rtl/port_select_lock_pkg.sv
// Shared types and helpers for the ingress-to-egress port selector.
package port_select_pkg;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic RD_DIR = 1'b1;

    // True when sel addresses a real port (matters for non-power-of-two counts).
    function automatic logic sel_in_range(input int sel, input int n);
        return (sel >= 0) && (sel < n);
    endfunction

endpackage

// File: rtl/port_select_lock_mux.sv
// AND-OR N:1 mux driven by a one-hot select; an all-zero select yields zero.
module port_mux_onehot #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel_oh,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int p = 0; p < N; p++)
            dout |= din[p*W +: W] & {W{sel_oh[p]}};
    end

endmodule

// File: rtl/port_select_lock.sv
// N-port ingress selector that holds the chosen port for a whole transaction,
// with a watchdog that forces the lock open after TIMEOUT locked cycles.
module port_select_lock
    import port_select_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS),
    parameter int AD_W      = 39,
    parameter int RD_W      = 32,
    parameter int SZ_W      = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          ig_sel,
    input  logic [NUM_PORTS-1:0]      int_read_write_i,
    input  logic [NUM_PORTS-1:0]      int_valid_i,
    input  logic [NUM_PORTS-1:0]      trans_started_i,
    input  logic [NUM_PORTS-1:0]      current_read_write_i,
    input  logic [NUM_PORTS*SZ_W-1:0] int_size_i,
    input  logic [NUM_PORTS*AD_W-1:0] int_addr_data_i,
    output logic [NUM_PORTS-1:0]      int_ready_o,
    output logic [NUM_PORTS-1:0]      new_tran_o,
    output logic [NUM_PORTS-1:0]      int_read_done_o,
    output logic [NUM_PORTS*RD_W-1:0] int2ig_data_o,
    output logic                      int_read_write,
    output logic                      int_valid,
    output logic                      trans_started,
    output logic                      current_read_write,
    output logic [SZ_W-1:0]           int_size,
    output logic [AD_W-1:0]           int_addr_data,
    input  logic                      int_ready,
    input  logic                      new_tran,
    input  logic [RD_W-1:0]           int2ig_data,
    input  logic                      int_read_done,
    output logic                      sel_locked,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      timeout_err
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q;
    logic [WD_W-1:0]      wd_cnt;
    logic [SEL_W-1:0]     eff_sel;
    logic [NUM_PORTS-1:0] sel_oh;
    logic [NUM_PORTS*4-1:0] req_bits;
    logic                 mux_valid, mux_ts;
    logic                 release_req, wd_fire;

    assign eff_sel    = (state_q == LOCKED) ? sel_q : ig_sel;
    assign cur_sel    = eff_sel;
    assign sel_locked = (state_q == LOCKED);

    always_comb begin
        sel_oh = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            sel_oh[p] = sel_in_range(int'(eff_sel), NUM_PORTS) && (eff_sel == SEL_W'(p));
    end

    // The four 1-bit request fields share one mux, packed per port.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
        assign req_bits[p*4 +: 4] = {int_read_write_i[p], int_valid_i[p],
                                     trans_started_i[p], current_read_write_i[p]};
    end

    port_mux_onehot #(.N(NUM_PORTS), .W(4)) u_mux_bits (
        .sel_oh (sel_oh),
        .din    (req_bits),
        .dout   ({int_read_write, mux_valid, mux_ts, current_read_write})
    );

    port_mux_onehot #(.N(NUM_PORTS), .W(SZ_W)) u_mux_size (
        .sel_oh (sel_oh),
        .din    (int_size_i),
        .dout   (int_size)
    );

    port_mux_onehot #(.N(NUM_PORTS), .W(AD_W)) u_mux_ad (
        .sel_oh (sel_oh),
        .din    (int_addr_data_i),
        .dout   (int_addr_data)
    );

    assign int_valid     = mux_valid & ~rst;
    assign trans_started = mux_ts & ~rst;

    assign int_ready_o     = sel_oh & {NUM_PORTS{int_ready & ~rst}};
    assign new_tran_o      = sel_oh & {NUM_PORTS{new_tran & ~rst}};
    assign int_read_done_o = sel_oh & {NUM_PORTS{int_read_done & ~rst}};
    assign int2ig_data_o   = {NUM_PORTS{int2ig_data}};

    assign release_req = new_tran | (int_read_done & (current_read_write == RD_DIR));
    assign wd_fire     = (TIMEOUT != 0) && (wd_cnt == WD_LAST) && !release_req;
    assign timeout_err = (state_q == LOCKED) && wd_fire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (int_valid && int_ready) state_d = LOCKED;
            LOCKED:  if (release_req || wd_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wd_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == LOCKED)
                sel_q <= ig_sel;
            // Counter restarts on every lock entry and sits at zero while idle.
            if (state_q != LOCKED || state_d != LOCKED)
                wd_cnt <= '0;
            else if (wd_cnt != '1)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_port_select_lock.sv
// Drives a 4-port (TIMEOUT=8) and a 3-port (watchdog off) selector from shared
// stimulus and compares both against a transaction-level model every cycle.
module tb_port_select_lock;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   ig_sel;
    logic [3:0]   rw_i, vi, ts_i, crw_i;
    logic [7:0]   sz_i;
    logic [155:0] ad_i;
    logic         int_ready, new_tran, int_read_done;
    logic [31:0]  rdata;

    logic [3:0]   o4_rdy, o4_nt, o4_rdn;
    logic [127:0] o4_data;
    logic         o4_rw, o4_v, o4_ts, o4_crw, o4_lock, o4_to;
    logic [1:0]   o4_sz, o4_sel;
    logic [38:0]  o4_ad;

    logic [2:0]   o3_rdy, o3_nt, o3_rdn;
    logic [95:0]  o3_data;
    logic         o3_rw, o3_v, o3_ts, o3_crw, o3_lock, o3_to;
    logic [1:0]   o3_sz, o3_sel;
    logic [38:0]  o3_ad;

    int n_chk  = 0;
    int n_pass = 0;

    bit m_lock[2];
    int m_port[2];
    int m_age[2];

    always #5 clk = ~clk;

    port_select_lock #(.NUM_PORTS(4), .TIMEOUT(8)) dut4 (
        .clk(clk), .rst(rst), .ig_sel(ig_sel),
        .int_read_write_i(rw_i), .int_valid_i(vi), .trans_started_i(ts_i),
        .current_read_write_i(crw_i), .int_size_i(sz_i), .int_addr_data_i(ad_i),
        .int_ready_o(o4_rdy), .new_tran_o(o4_nt), .int_read_done_o(o4_rdn),
        .int2ig_data_o(o4_data), .int_read_write(o4_rw), .int_valid(o4_v),
        .trans_started(o4_ts), .current_read_write(o4_crw), .int_size(o4_sz),
        .int_addr_data(o4_ad), .int_ready(int_ready), .new_tran(new_tran),
        .int2ig_data(rdata), .int_read_done(int_read_done),
        .sel_locked(o4_lock), .cur_sel(o4_sel), .timeout_err(o4_to)
    );

    port_select_lock #(.NUM_PORTS(3), .TIMEOUT(0)) dut3 (
        .clk(clk), .rst(rst), .ig_sel(ig_sel),
        .int_read_write_i(rw_i[2:0]), .int_valid_i(vi[2:0]), .trans_started_i(ts_i[2:0]),
        .current_read_write_i(crw_i[2:0]), .int_size_i(sz_i[5:0]),
        .int_addr_data_i(ad_i[116:0]),
        .int_ready_o(o3_rdy), .new_tran_o(o3_nt), .int_read_done_o(o3_rdn),
        .int2ig_data_o(o3_data), .int_read_write(o3_rw), .int_valid(o3_v),
        .trans_started(o3_ts), .current_read_write(o3_crw), .int_size(o3_sz),
        .int_addr_data(o3_ad), .int_ready(int_ready), .new_tran(new_tran),
        .int2ig_data(rdata), .int_read_done(int_read_done),
        .sel_locked(o3_lock), .cur_sel(o3_sel), .timeout_err(o3_to)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Model: a port is held from the handshake until new_tran, a read-done on a
    // read transfer, or TIMEOUT locked cycles without either.
    task automatic eval(input int i);
        int np, tmo, eff;
        bit inr, rel, wd;
        logic ev, ets, erw, ecrw;
        logic [1:0] esz, esel;
        logic [38:0] ead;
        logic [3:0] e_rdy, e_nt, e_rdn;
        logic [127:0] e_data;
        logic [3:0] g_rdy, g_nt, g_rdn;
        logic [127:0] g_data;
        logic g_rw, g_v, g_ts, g_crw, g_lock, g_to;
        logic [1:0] g_sz, g_sel;
        logic [38:0] g_ad;
        string px;

        np  = (i == 0) ? 4 : 3;
        tmo = (i == 0) ? 8 : 0;
        px  = $sformatf("p%0d_", np);
        if (i == 0) begin
            g_rdy = o4_rdy; g_nt = o4_nt; g_rdn = o4_rdn; g_data = o4_data;
            g_rw = o4_rw; g_v = o4_v; g_ts = o4_ts; g_crw = o4_crw;
            g_sz = o4_sz; g_ad = o4_ad; g_lock = o4_lock; g_sel = o4_sel; g_to = o4_to;
        end else begin
            g_rdy = {1'b0, o3_rdy}; g_nt = {1'b0, o3_nt}; g_rdn = {1'b0, o3_rdn};
            g_data = {32'h0, o3_data};
            g_rw = o3_rw; g_v = o3_v; g_ts = o3_ts; g_crw = o3_crw;
            g_sz = o3_sz; g_ad = o3_ad; g_lock = o3_lock; g_sel = o3_sel; g_to = o3_to;
        end

        if (rst) begin m_lock[i] = 0; m_age[i] = 0; end
        eff  = m_lock[i] ? m_port[i] : int'(ig_sel);
        esel = 2'(eff);
        inr  = eff < np;
        {ev, ets, erw, ecrw, esz, ead, e_rdy, e_nt, e_rdn} = '0;
        if (inr) begin
            ev   = vi[eff] && !rst;
            ets  = ts_i[eff] && !rst;
            erw  = rw_i[eff];
            ecrw = crw_i[eff];
            esz  = sz_i[eff*2 +: 2];
            ead  = ad_i[eff*39 +: 39];
            e_rdy[eff] = int_ready && !rst;
            e_nt[eff]  = new_tran && !rst;
            e_rdn[eff] = int_read_done && !rst;
        end
        e_data = '0;
        for (int p = 0; p < np; p++) e_data[p*32 +: 32] = rdata;
        rel = new_tran || (int_read_done && ecrw);
        wd  = (tmo != 0) && m_lock[i] && !rel && (m_age[i] == tmo - 1);

        chk({px, "sel_locked"}, g_lock, m_lock[i]);
        chk({px, "cur_sel"}, g_sel, esel);
        chk({px, "int_valid"}, g_v, ev);
        chk({px, "trans_started"}, g_ts, ets);
        chk({px, "req_bits"}, {g_rw, g_crw, g_sz}, {erw, ecrw, esz});
        chk({px, "addr_data"}, g_ad, ead);
        chk({px, "int_ready_o"}, g_rdy, e_rdy);
        chk({px, "new_tran_o"}, g_nt, e_nt);
        chk({px, "read_done_o"}, g_rdn, e_rdn);
        chk({px, "rd_data_o"}, g_data, e_data);
        chk({px, "timeout_err"}, g_to, wd);

        if (!rst) begin
            if (!m_lock[i]) begin
                if (ev && int_ready) begin
                    m_lock[i] = 1; m_port[i] = int'(ig_sel); m_age[i] = 0;
                end
            end else if (rel || wd) begin
                m_lock[i] = 0; m_age[i] = 0;
            end else begin
                m_age[i]++;
            end
        end
    endtask

    // Inputs are set at the falling edge; checks run 1ns later, before the rising edge.
    task automatic cyc();
        #1;
        eval(0);
        eval(1);
        @(negedge clk);
    endtask

    task automatic rnd_data();
        rw_i  = 4'($urandom());
        vi    = 4'($urandom());
        ts_i  = 4'($urandom());
        crw_i = 4'($urandom());
        sz_i  = 8'($urandom());
        rdata = $urandom();
        for (int p = 0; p < 4; p++) ad_i[p*39 +: 39] = 39'({$urandom(), $urandom()});
    endtask

    initial begin
        rst = 1'b1; ig_sel = 2'd0; int_ready = 1'b0; new_tran = 1'b0; int_read_done = 1'b0;
        ad_i = '0;
        rnd_data();
        vi = 4'b0;
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // lock port 1, then move the arbiter; port 1 must stay selected
        ig_sel = 2'd1; vi = 4'b0010; int_ready = 1'b1;
        cyc();
        ig_sel = 2'd3; rnd_data(); crw_i = 4'b0;
        cyc(); cyc();
        new_tran = 1'b1; cyc();
        new_tran = 1'b0; int_ready = 1'b0; cyc();

        // read-done only releases a read transfer
        ig_sel = 2'd2; vi = 4'b0100; int_ready = 1'b1; crw_i = 4'b0;
        cyc();
        int_ready = 1'b0; int_read_done = 1'b1; cyc();
        crw_i = 4'b1111; cyc();
        int_read_done = 1'b0; cyc();

        // watchdog on the 4-port instance
        ig_sel = 2'd0; vi = 4'b0001; int_ready = 1'b1; crw_i = 4'b0;
        cyc();
        int_ready = 1'b0;
        repeat (10) cyc();

        // async reset in the middle of a lock
        ig_sel = 2'd2; vi = 4'b0100; int_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; ig_sel = 2'd1; int_ready = 1'b0; cyc();

        // out-of-range select on the 3-port instance
        ig_sel = 2'd3; vi = 4'b1111; int_ready = 1'b1; new_tran = 1'b1;
        cyc(); new_tran = 1'b0; cyc();

        repeat (600) begin
            ig_sel        = 2'($urandom());
            rnd_data();
            int_ready     = 1'($urandom());
            new_tran      = ($urandom_range(0, 5) == 0);
            int_read_done = ($urandom_range(0, 4) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
